cont_tick_prog: RTL and testbench

Multi-channel programmable tick/square-wave generator clocked from the 50 MHz board clock. It generalises the fixed one-second toggle counter into N_CH independent channels. Each channel has a runtime-loadable divisor, a periodic or one-shot mode, a per-channel enable, a one-cycle tick strobe and a toggling square output. It feeds display refresh, debounce sampling and seconds timing elsewhere in the design.

---
 rtl/cont_tick_prog.sv | 102 ++++++++++
 tb/tb_cont_tick_prog.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cont_tick_prog.sv
// rtl/cont_tick_prog.sv - multi-channel programmable tick/square-wave generator
module cont_tick_prog #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 25000000
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  square,
  output logic [N_CH-1:0]  done,
  input  logic [CH_W-1:0]  sel_ch,
  output logic [CNT_W-1:0] sel_div,
  output logic [CNT_W-1:0] sel_cnt
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] r_div [N_CH];
  logic [CNT_W-1:0] r_cnt [N_CH];
  logic [N_CH-1:0]  r_mode;
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  r_square;
  logic [N_CH-1:0]  r_done;

  logic [N_CH-1:0]  w_wr_hit;
  logic [N_CH-1:0]  w_idle;
  logic [N_CH-1:0]  w_term;

  // Per-channel decode: write target, idle condition and terminal count.
  // An out-of-range wr_ch matches no channel, so such writes fall away.
  always_comb begin
    w_wr_hit = '0;
    w_idle   = '0;
    w_term   = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      w_wr_hit[ch] = wr_en && (wr_ch == CH_W'(ch));
      w_idle[ch]   = !en[ch] || (r_div[ch] == '0) || (r_mode[ch] && r_done[ch]);
      w_term[ch]   = (r_cnt[ch] == (r_div[ch] - CNT_W'(1)));
    end
  end

  // Channel state update: reset, then write, idle, terminal, count.
  always_ff @(posedge mclk) begin
    if (!reset) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        r_div[ch] <= DEF_DIV_W;
        r_cnt[ch] <= '0;
      end
      r_mode   <= '0;
      r_tick   <= '0;
      r_square <= '0;
      r_done   <= '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (w_wr_hit[ch]) begin
          // A write always restarts the count, even on a terminal cycle.
          r_div[ch]  <= wr_div;
          r_mode[ch] <= wr_mode;
          r_cnt[ch]  <= '0;
          r_done[ch] <= 1'b0;
          r_tick[ch] <= 1'b0;
        end else if (w_idle[ch]) begin
          r_tick[ch] <= 1'b0;
        end else if (w_term[ch]) begin
          r_cnt[ch]    <= '0;
          r_tick[ch]   <= 1'b1;
          r_square[ch] <= ~r_square[ch];
          if (r_mode[ch]) begin
            r_done[ch] <= 1'b1;
          end
        end else begin
          r_cnt[ch]  <= r_cnt[ch] + CNT_W'(1);
          r_tick[ch] <= 1'b0;
        end
      end
    end
  end

  // Read-back mux; unpopulated channel numbers read as zero.
  always_comb begin
    sel_div = '0;
    sel_cnt = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (sel_ch == CH_W'(ch)) begin
        sel_div = r_div[ch];
        sel_cnt = r_cnt[ch];
      end
    end
  end

  assign tick   = r_tick;
  assign square = r_square;
  assign done   = r_done;

endmodule

// File: tb/tb_cont_tick_prog.sv
// tb/tb_cont_tick_prog.sv - directed table-driven bench for cont_tick_prog
module tb_cont_tick_prog;

  localparam int N_CH    = 4;
  localparam int CH_W    = 2;
  localparam int CNT_W   = 26;
  localparam int DEF_DIV = 25000000;

  logic             mclk;
  logic             reset;
  logic [N_CH-1:0]  en;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  square;
  logic [N_CH-1:0]  done;
  logic [CH_W-1:0]  sel_ch;
  logic [CNT_W-1:0] sel_div;
  logic [CNT_W-1:0] sel_cnt;

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0]  en;
    logic        we;
    logic [1:0]  wch;
    logic [25:0] wdiv;
    logic        wmode;
    int          ch;
    logic        t;
    logic        s;
    logic        d;
    logic [25:0] c;
  } vec_t;

  vec_t vq[$];

  cont_tick_prog #(
    .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)
  ) dut (
    .mclk(mclk), .reset(reset), .en(en),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
    .tick(tick), .square(square), .done(done),
    .sel_ch(sel_ch), .sel_div(sel_div), .sel_cnt(sel_cnt)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  function automatic vec_t mk(input logic [3:0] e, input logic we, input logic [1:0] wch,
                              input logic [25:0] wdiv, input logic wmode, input int ch,
                              input logic t, input logic s, input logic d, input logic [25:0] c);
    vec_t v;
    v.en = e; v.we = we; v.wch = wch; v.wdiv = wdiv; v.wmode = wmode;
    v.ch = ch; v.t = t; v.s = s; v.d = d; v.c = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    en      = r.en;
    wr_en   = r.we;
    wr_ch   = r.wch;
    wr_div  = r.wdiv;
    wr_mode = r.wmode;
    sel_ch  = 2'(r.ch);
    @(negedge mclk);
    chk($sformatf("row%0d_tick", idx),   32'(tick[r.ch]),   32'(r.t));
    chk($sformatf("row%0d_square", idx), 32'(square[r.ch]), 32'(r.s));
    chk($sformatf("row%0d_done", idx),   32'(done[r.ch]),   32'(r.d));
    chk($sformatf("row%0d_cnt", idx),    32'(sel_cnt),      32'(r.c));
    wr_en = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0; sel_ch = '0;

    // ch0 div=5 periodic: ticks on enabled edges 5,10,15,20
    vq.push_back(mk(4'b0001, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 4));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 3));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 0, 1, 0, 4));
    vq.push_back(mk(4'b0001, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // ch1 div=3 one-shot: single tick, then done holds; rewrite restarts
    vq.push_back(mk(4'b0010, 1, 1, 3, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    for (int k = 0; k < 17; k++) vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    vq.push_back(mk(4'b0010, 1, 1, 3, 1, 1, 0, 1, 0, 0));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 0, 1, 0, 2));
    vq.push_back(mk(4'b0010, 0, 0, 0, 0, 1, 1, 0, 1, 0));
    // ch2 div=4: freeze at cnt=2 for 7 cycles, tick 2 enabled edges later
    vq.push_back(mk(4'b0100, 1, 2, 4, 0, 2, 0, 0, 0, 0));
    vq.push_back(mk(4'b0100, 0, 0, 0, 0, 2, 0, 0, 0, 1));
    vq.push_back(mk(4'b0100, 0, 0, 0, 0, 2, 0, 0, 0, 2));
    for (int k = 0; k < 7; k++) vq.push_back(mk(4'b0000, 0, 0, 0, 0, 2, 0, 0, 0, 2));
    vq.push_back(mk(4'b0100, 0, 0, 0, 0, 2, 0, 0, 0, 3));
    vq.push_back(mk(4'b0100, 0, 0, 0, 0, 2, 1, 1, 0, 0));
    vq.push_back(mk(4'b0100, 0, 0, 0, 0, 2, 0, 1, 0, 1));
    // ch3 div=1 continuous tick, div=0 stop, write on terminal cycle
    vq.push_back(mk(4'b1000, 1, 3, 1, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 1, 1, 0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 1, 1, 0, 0));
    vq.push_back(mk(4'b1000, 1, 3, 0, 0, 3, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(4'b1000, 1, 3, 4, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 1));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 2));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 3));
    vq.push_back(mk(4'b1000, 1, 3, 4, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 1));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 2));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 0, 1, 0, 3));
    vq.push_back(mk(4'b1000, 0, 0, 0, 0, 3, 1, 0, 0, 0));

    // Reset held for two edges
    repeat (2) @(negedge mclk);
    for (int ch = 0; ch < N_CH; ch++) begin
      sel_ch = 2'(ch);
      #1;
      chk($sformatf("rst_div%0d", ch), 32'(sel_div), 32'(DEF_DIV));
      chk($sformatf("rst_cnt%0d", ch), 32'(sel_cnt), 32'd0);
    end
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_square", 32'(square), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge mclk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply_row(vq[i], i);

    // Divisors written above read back per channel
    en = '0;
    sel_ch = 2'd0; #1; chk("rb_div0", 32'(sel_div), 32'd5);
    sel_ch = 2'd1; #1; chk("rb_div1", 32'(sel_div), 32'd3);
    sel_ch = 2'd2; #1; chk("rb_div2", 32'(sel_div), 32'd4);
    sel_ch = 2'd3; #1; chk("rb_div3", 32'(sel_div), 32'd4);

    // Mid-count reset with a coincident write that must be discarded
    @(negedge mclk);
    en = 4'b1111;
    sel_ch = 2'd0;
    repeat (3) @(negedge mclk);
    chk("pre_rst_cnt0", 32'(sel_cnt), 32'd3);
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_ch   = 2'd1;
    wr_div  = 26'd9;
    wr_mode = 1'b1;
    @(negedge mclk);
    chk("mid_rst_tick", 32'(tick), 32'd0);
    chk("mid_rst_square", 32'(square), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    for (int ch = 0; ch < N_CH; ch++) begin
      sel_ch = 2'(ch);
      #1;
      chk($sformatf("mid_rst_div%0d", ch), 32'(sel_div), 32'(DEF_DIV));
      chk($sformatf("mid_rst_cnt%0d", ch), 32'(sel_cnt), 32'd0);
    end
    @(negedge mclk);
    reset = 1'b1;
    wr_en = 1'b0;
    en    = '0;
    sel_ch = 2'd1;
    @(negedge mclk);
    chk("post_rst_div1", 32'(sel_div), 32'(DEF_DIV));
    chk("post_rst_cnt1", 32'(sel_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
